skor_tablosu: RTL and testbench

Match-level scoreboard directly downstream of the three-player round-resolution stage. It takes one round result per valid pulse: the winning player id (0 = no winner) and the round's net score. It accumulates per-player win counts, draws and total match points over a fixed number of rounds, then declares a match champion. All outputs are registered; the block holds its result until a new match is started.

---
 rtl/skor_tablosu_pkg.sv | 20 ++
 rtl/skor_tablosu_sampiyon_secici.sv | 40 ++++
 rtl/skor_tablosu.sv | 126 ++++++++++++
 tb/tb_skor_tablosu.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skor_tablosu_pkg.sv
// Shared types and constants for the match scoreboard: FSM states, player ids
// and the tie-break priority order used by the champion selector.
package skor_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    OYUN  = 2'd1,
    HESAP = 2'd2,
    BITTI = 2'd3
  } durum_t;

  localparam logic [1:0] OYUNCU_YOK = 2'd0;
  localparam logic [1:0] OYUNCU1    = 2'd1;
  localparam logic [1:0] OYUNCU2    = 2'd2;
  localparam logic [1:0] OYUNCU3    = 2'd3;

  // Highest priority in the top slot; same order as the round-resolution stage.
  localparam logic [5:0] ONCELIK = {OYUNCU1, OYUNCU3, OYUNCU2};

endpackage

// File: rtl/skor_tablosu_sampiyon_secici.sv
// Combinational champion pick: player with the most wins, ties resolved by
// ONCELIK order, no champion when nobody has won a round.
module sampiyon_secici
  import skor_pkg::*;
(
  input  logic [3:0] galibiyet1,
  input  logic [3:0] galibiyet2,
  input  logic [3:0] galibiyet3,
  output logic [1:0] sampiyon
);

  logic [3:0] en_cok;
  logic [1:0] aday;

  function automatic logic [3:0] galibiyet_of(input logic [1:0] id, input logic [3:0] g1,
                                              input logic [3:0] g2, input logic [3:0] g3);
    case (id)
      OYUNCU1: galibiyet_of = g1;
      OYUNCU2: galibiyet_of = g2;
      OYUNCU3: galibiyet_of = g3;
      default: galibiyet_of = 4'd0;
    endcase
  endfunction

  always_comb begin
    en_cok   = galibiyet1;
    aday     = OYUNCU_YOK;
    sampiyon = OYUNCU_YOK;
    if (galibiyet2 > en_cok) en_cok = galibiyet2;
    if (galibiyet3 > en_cok) en_cok = galibiyet3;
    // Walk the priority list; the first player holding the maximum wins.
    for (int i = 0; i < 3; i++) begin
      if (aday == OYUNCU_YOK &&
          galibiyet_of(ONCELIK[5-2*i -: 2], galibiyet1, galibiyet2, galibiyet3) == en_cok)
        aday = ONCELIK[5-2*i -: 2];
    end
    if (en_cok != 4'd0) sampiyon = aday;
  end

endmodule

// File: rtl/skor_tablosu.sv
// Match scoreboard: accepts one round per cycle while hazir, counts wins/draws and
// saturating points, then registers the champion one cycle after the last round.
module skor_tablosu
  import skor_pkg::*;
#(
  parameter int TUR_SAYISI = 5,
  parameter int PUAN_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              yeni_mac,
  input  logic              tur_gecerli,
  input  logic [1:0]        kazanan,
  input  logic [4:0]        toplam_puan,
  output logic              hazir,
  output logic [3:0]        tur_no,
  output logic [3:0]        galibiyet1,
  output logic [3:0]        galibiyet2,
  output logic [3:0]        galibiyet3,
  output logic [3:0]        beraberlik,
  output logic [PUAN_W-1:0] mac_puani,
  output logic              mac_bitti,
  output logic [1:0]        sampiyon
);

  durum_t            durum_q, durum_d;
  logic [3:0]        tur_no_q, tur_no_d;
  logic [3:0]        gal1_q, gal1_d, gal2_q, gal2_d, gal3_q, gal3_d;
  logic [3:0]        ber_q, ber_d;
  logic [PUAN_W-1:0] puan_q, puan_d;
  logic [1:0]        sampiyon_q, sampiyon_d;
  logic              hazir_q, hazir_d, bitti_q, bitti_d;
  logic [PUAN_W:0]   puan_toplam;
  logic [1:0]        secilen;

  sampiyon_secici u_secici (
    .galibiyet1 (gal1_q),
    .galibiyet2 (gal2_q),
    .galibiyet3 (gal3_q),
    .sampiyon   (secilen)
  );

  // One spare bit catches the carry that drives saturation.
  assign puan_toplam = {1'b0, puan_q} + {{(PUAN_W-4){1'b0}}, toplam_puan};

  always_comb begin
    durum_d    = durum_q;
    tur_no_d   = tur_no_q;
    gal1_d     = gal1_q;
    gal2_d     = gal2_q;
    gal3_d     = gal3_q;
    ber_d      = ber_q;
    puan_d     = puan_q;
    sampiyon_d = sampiyon_q;
    if (yeni_mac) begin
      durum_d    = OYUN;
      tur_no_d   = 4'd0;
      gal1_d     = 4'd0;
      gal2_d     = 4'd0;
      gal3_d     = 4'd0;
      ber_d      = 4'd0;
      puan_d     = '0;
      sampiyon_d = OYUNCU_YOK;
    end else begin
      case (durum_q)
        OYUN: begin
          if (tur_gecerli) begin
            case (kazanan)
              OYUNCU1: gal1_d = gal1_q + 4'd1;
              OYUNCU2: gal2_d = gal2_q + 4'd1;
              OYUNCU3: gal3_d = gal3_q + 4'd1;
              default: ber_d  = ber_q + 4'd1;
            endcase
            puan_d   = puan_toplam[PUAN_W] ? '1 : puan_toplam[PUAN_W-1:0];
            tur_no_d = tur_no_q + 4'd1;
            if (tur_no_d == 4'(TUR_SAYISI)) durum_d = HESAP;
          end
        end
        HESAP: begin
          sampiyon_d = secilen;
          durum_d    = BITTI;
        end
        default: durum_d = durum_q;
      endcase
    end
    hazir_d = (durum_d == OYUN);
    bitti_d = (durum_d == BITTI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q    <= BOSTA;
      tur_no_q   <= 4'd0;
      gal1_q     <= 4'd0;
      gal2_q     <= 4'd0;
      gal3_q     <= 4'd0;
      ber_q      <= 4'd0;
      puan_q     <= '0;
      sampiyon_q <= OYUNCU_YOK;
      hazir_q    <= 1'b0;
      bitti_q    <= 1'b0;
    end else begin
      durum_q    <= durum_d;
      tur_no_q   <= tur_no_d;
      gal1_q     <= gal1_d;
      gal2_q     <= gal2_d;
      gal3_q     <= gal3_d;
      ber_q      <= ber_d;
      puan_q     <= puan_d;
      sampiyon_q <= sampiyon_d;
      hazir_q    <= hazir_d;
      bitti_q    <= bitti_d;
    end
  end

  assign hazir      = hazir_q;
  assign tur_no     = tur_no_q;
  assign galibiyet1 = gal1_q;
  assign galibiyet2 = gal2_q;
  assign galibiyet3 = gal3_q;
  assign beraberlik = ber_q;
  assign mac_puani  = puan_q;
  assign mac_bitti  = bitti_q;
  assign sampiyon   = sampiyon_q;

endmodule

// File: tb/tb_skor_tablosu.sv
// Scoreboard bench for skor_tablosu: a driver updates a reference model and queues
// expected snapshots; a monitor pops and compares on every accepted round and match end.
module tb_skor_tablosu;

  localparam int TS = 5;
  localparam int PW = 6;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          yeni_mac = 1'b0;
  logic          tur_gecerli = 1'b0;
  logic [1:0]    kazanan = 2'd0;
  logic [4:0]    toplam_puan = 5'd0;
  logic          hazir, mac_bitti;
  logic [3:0]    tur_no, galibiyet1, galibiyet2, galibiyet3, beraberlik;
  logic [PW-1:0] mac_puani;
  logic [1:0]    sampiyon;

  skor_tablosu #(.TUR_SAYISI(TS), .PUAN_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .yeni_mac    (yeni_mac),
    .tur_gecerli (tur_gecerli),
    .kazanan     (kazanan),
    .toplam_puan (toplam_puan),
    .hazir       (hazir),
    .tur_no      (tur_no),
    .galibiyet1  (galibiyet1),
    .galibiyet2  (galibiyet2),
    .galibiyet3  (galibiyet3),
    .beraberlik  (beraberlik),
    .mac_puani   (mac_puani),
    .mac_bitti   (mac_bitti),
    .sampiyon    (sampiyon)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tur; int g1; int g2; int g3; int ber; int puan; int hazir; int samp;
  } snap_t;

  snap_t exp_tur_q[$];
  snap_t exp_son_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain counts per player id, points clamped to the maximum.
  int m_g[4];
  int m_tur, m_puan, m_samp;
  bit m_hazir = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_champ();
    int best = 0;
    int key_best = -1;
    for (int p = 1; p <= 3; p++) begin
      int key = m_g[p] * 4 + ((p == 1) ? 2 : (p == 3) ? 1 : 0);
      if (key > key_best) begin
        key_best = key;
        best = p;
      end
    end
    return (m_g[best] == 0) ? 0 : best;
  endfunction

  function automatic snap_t model_snap(input int hz, input int sp);
    snap_t s;
    s.tur = m_tur; s.g1 = m_g[1]; s.g2 = m_g[2]; s.g3 = m_g[3];
    s.ber = m_g[0]; s.puan = m_puan; s.hazir = hz; s.samp = sp;
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_g[i] = 0;
    m_tur = 0; m_puan = 0; m_samp = 0;
  endtask

  task automatic drive(input bit ym, input bit tv, input int k, input int p);
    @(negedge clk);
    yeni_mac = ym; tur_gecerli = tv; kazanan = 2'(k); toplam_puan = 5'(p);
    if (ym) begin
      model_clear();
      m_hazir = 1'b1;
    end else if (tv && m_hazir) begin
      m_g[k]++;
      m_tur++;
      m_puan = (m_puan + p > PMAX) ? PMAX : m_puan + p;
      exp_tur_q.push_back(model_snap((m_tur < TS) ? 1 : 0, 0));
      if (m_tur == TS) begin
        m_hazir = 1'b0;
        m_samp = model_champ();
        exp_son_q.push_back(model_snap(0, m_samp));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic cmp_snap(input string tag, input snap_t e);
    chk({tag, ".tur_no"}, tur_no, e.tur);
    chk({tag, ".galibiyet1"}, galibiyet1, e.g1);
    chk({tag, ".galibiyet2"}, galibiyet2, e.g2);
    chk({tag, ".galibiyet3"}, galibiyet3, e.g3);
    chk({tag, ".beraberlik"}, beraberlik, e.ber);
    chk({tag, ".mac_puani"}, mac_puani, e.puan);
    chk({tag, ".hazir"}, hazir, e.hazir);
    chk({tag, ".sampiyon"}, sampiyon, e.samp);
  endtask

  task automatic chk_zero(input string tag);
    cmp_snap(tag, '{0, 0, 0, 0, 0, 0, 0, 0});
    chk({tag, ".mac_bitti"}, mac_bitti, 0);
  endtask

  // Monitor: sample inputs just before each rising edge, compare just after it.
  initial begin
    int  cyc = 0;
    int  cyc_son = 0;
    bit  acc_pre, bitti_pre;
    forever begin
      @(negedge clk);
      #4;
      acc_pre   = rst_n && hazir && tur_gecerli && !yeni_mac;
      bitti_pre = mac_bitti;
      @(posedge clk);
      #1;
      cyc++;
      if (acc_pre) begin
        cyc_son = cyc;
        if (exp_tur_q.size() == 0) chk("tur_beklenmeyen_kabul", 1, 0);
        else cmp_snap("tur", exp_tur_q.pop_front());
      end
      if (!bitti_pre && mac_bitti) begin
        if (exp_son_q.size() == 0) chk("son_beklenmeyen_bitis", 1, 0);
        else begin
          cmp_snap("son", exp_son_q.pop_front());
          chk("son.bitti_gecikme", cyc - cyc_son, 1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b1, 1, 10);
    idle(1);
    chk_zero("bosta_yoksay");

    // Full directed match
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1, 10);
    drive(1'b0, 1'b1, 3, 4);
    drive(1'b0, 1'b1, 1, 7);
    drive(1'b0, 1'b1, 0, 0);
    drive(1'b0, 1'b1, 2, 31);
    idle(3);
    cmp_snap("tam_mac", '{5, 2, 1, 1, 1, 52, 0, 1});
    chk("tam_mac.mac_bitti", mac_bitti, 1);
    repeat (3) drive(1'b0, 1'b1, 2, 20);
    idle(1);
    cmp_snap("bitti_yoksay", '{5, 2, 1, 1, 1, 52, 0, 1});
    chk("bitti_yoksay.mac_bitti", mac_bitti, 1);

    // Tie-break 3 over 2
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 3, 1);
    drive(1'b0, 1'b1, 2, 1);
    repeat (3) drive(1'b0, 1'b1, 0, 1);
    idle(3);
    chk("esitlik_3_2.sampiyon", sampiyon, 3);

    // All draws
    drive(1'b1, 1'b0, 0, 0);
    repeat (5) drive(1'b0, 1'b1, 0, 2);
    idle(3);
    chk("hep_berabere.sampiyon", sampiyon, 0);
    chk("hep_berabere.beraberlik", beraberlik, 5);

    // Saturation
    drive(1'b1, 1'b0, 0, 0);
    repeat (5) drive(1'b0, 1'b1, 2, 31);
    idle(3);
    chk("doyma.mac_puani", mac_puani, PMAX);

    // yeni_mac wins over a simultaneous round
    drive(1'b1, 1'b1, 1, 9);
    idle(1);
    cmp_snap("yeni_mac_oncelik", '{0, 0, 0, 0, 0, 0, 1, 0});

    // Abort by reset after round 3
    drive(1'b0, 1'b1, 1, 5);
    drive(1'b0, 1'b1, 2, 6);
    drive(1'b0, 1'b1, 3, 7);
    @(negedge clk);
    tur_gecerli = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("iptal");
    model_clear();
    m_hazir = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 31));
    idle(3);
    chk("iptal_sonrasi.mac_bitti", mac_bitti, 1);
    chk("iptal_sonrasi.sampiyon", sampiyon, m_samp);

    // Randomized matches with gaps, restarts and ignored pulses
    for (int mac = 0; mac < 30; mac++) begin
      drive(1'b1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 31));
      for (int c = 0; c < 80 && m_hazir; c++) begin
        drive($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 3), $urandom_range(0, 31));
      end
      idle(2);
      chk("rastgele.mac_bitti", mac_bitti, 1);
      chk("rastgele.sampiyon", sampiyon, m_samp);
      chk("rastgele.mac_puani", mac_puani, m_puan);
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 31));
    end

    idle(3);
    chk("kuyruk_tur_bos", exp_tur_q.size(), 0);
    chk("kuyruk_son_bos", exp_son_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
